// File: rtl/herloa_err_eval.sv
// HERLOA error-characterisation engine: drives a HERLOA #(N,K) and an exact adder with LFSR
// operands and accumulates error count, sum and max of |approx - exact|. HERLOA_EVAL_SQ_EN adds sum_sq_ed.

// HERLOA #(N,K) approximate adder (requires 2 <= K < N).
// Bit K-1 is XOR patched with the AND of bit K-2; when bit K-1 generates, that carry feeds the
// upper part and the lower K-1 bits are forced high; otherwise they are plain OR.
module herloa #(
  parameter int unsigned N = 16,
  parameter int unsigned K = 12
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] s
);

  logic g;

  always_comb begin
    g          = a[K-1] & b[K-1];
    s[N-1:K]   = a[N-1:K] + b[N-1:K] + (N-K)'(g);
    s[K-1]     = (a[K-1] ^ b[K-1]) | (a[K-2] & b[K-2]);
    s[K-2:0]   = a[K-2:0] | b[K-2:0] | {(K-1){g}};
  end

endmodule

module herloa_err_eval #(
  parameter int unsigned N     = 16,
  parameter int unsigned K     = 12,
  parameter int unsigned CNT_W = 24,
  parameter logic [31:0] SEED  = 32'hACE1_2345
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_samples,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     err_count,
  output logic [N+CNT_W-1:0]   sum_ed,
`ifdef HERLOA_EVAL_SQ_EN
  output logic [2*N+CNT_W-1:0] sum_sq_ed,
`endif
  output logic [N-1:0]         max_ed
);

  localparam logic [31:0] LfsrTaps = 32'h8020_0003;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [31:0]      lfsr_q, lfsr_d, lfsr_next;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [1:0]       drain_q, drain_d;
  logic             issue, clear;

  logic             s1_valid_q, s2_valid_q, s3_valid_q;
  logic [N-1:0]     x_q, y_q;
  logic [N-1:0]     exact_q, approx_q, approx_d;
  logic [N-1:0]     ed_q, ed_d;
  logic             mis_q;
`ifdef HERLOA_EVAL_SQ_EN
  logic [2*N-1:0]   ed_sq_q;
`endif

  assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrTaps) : (lfsr_q >> 1);

  assign busy = (state_q == StRun) || (state_q == StDrain);
  assign done = (state_q == StDone);

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    remain_d = remain_q;
    drain_d  = drain_q;
    issue    = 1'b0;
    clear    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          clear    = 1'b1;
          lfsr_d   = SEED;
          remain_d = num_samples;
          state_d  = (num_samples == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        issue    = 1'b1;
        lfsr_d   = lfsr_next;
        remain_d = remain_q - CNT_W'(1);
        if (remain_q == CNT_W'(1)) begin
          state_d = StDrain;
          drain_d = 2'd0;
        end
      end
      StDrain: begin
        // Three cycles covers S2, S3 and the accumulate stage.
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd2) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      lfsr_q   <= SEED;
      remain_q <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      remain_q <= remain_d;
      drain_q  <= drain_d;
    end
  end

  herloa #(
    .N(N),
    .K(K)
  ) u_herloa (
    .a(x_q),
    .b(y_q),
    .s(approx_d)
  );

  assign ed_d = (approx_q >= exact_q) ? (approx_q - exact_q) : (exact_q - approx_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      exact_q    <= '0;
      approx_q   <= '0;
      ed_q       <= '0;
      mis_q      <= 1'b0;
`ifdef HERLOA_EVAL_SQ_EN
      ed_sq_q    <= '0;
`endif
    end else begin
      s1_valid_q <= issue;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      if (issue) begin
        x_q <= lfsr_q[N-1:0];
        y_q <= lfsr_q[16+N-1:16];
      end
      if (s1_valid_q) begin
        exact_q  <= x_q + y_q;
        approx_q <= approx_d;
      end
      if (s2_valid_q) begin
        ed_q  <= ed_d;
        mis_q <= (approx_q != exact_q);
`ifdef HERLOA_EVAL_SQ_EN
        ed_sq_q <= (2*N)'(ed_d) * (2*N)'(ed_d);
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
`ifdef HERLOA_EVAL_SQ_EN
      sum_sq_ed <= '0;
`endif
    end else if (clear) begin
      err_count <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
`ifdef HERLOA_EVAL_SQ_EN
      sum_sq_ed <= '0;
`endif
    end else if (s3_valid_q) begin
      if (mis_q && (err_count != '1)) err_count <= err_count + CNT_W'(1);
      sum_ed <= sum_ed + (N+CNT_W)'(ed_q);
      if (ed_q > max_ed) max_ed <= ed_q;
`ifdef HERLOA_EVAL_SQ_EN
      sum_sq_ed <= sum_sq_ed + (2*N+CNT_W)'(ed_sq_q);
`endif
    end
  end

endmodule

// File: tb/tb_herloa_err_eval.sv
// Scoreboard bench for herloa_err_eval: a software LFSR/HERLOA model pushes expected results
// at each start; they are popped and compared when the DUT pulses done.
module tb_herloa_err_eval;

  localparam int N     = 16;
  localparam int K     = 12;
  localparam int CNT_W = 24;

  typedef struct {
    logic [63:0] err;
    logic [63:0] sum;
    logic [63:0] max;
    int          cyc;
    int          m;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_a, start_b;
  logic [CNT_W-1:0] num_samples;
  logic             busy_a, busy_b, done_a, done_b;
  logic [CNT_W-1:0] err_a, err_b;
  logic [N+CNT_W-1:0] sum_a, sum_b;
  logic [N-1:0]     max_a, max_b;
`ifdef HERLOA_EVAL_SQ_EN
  logic [2*N+CNT_W-1:0] sq_a, sq_b;
`endif
  logic             sel;

  always #5 clk = ~clk;

  herloa_err_eval #(.N(N), .K(K), .CNT_W(CNT_W), .SEED(32'hACE1_2345)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .num_samples(num_samples),
    .busy(busy_a), .done(done_a), .err_count(err_a), .sum_ed(sum_a),
`ifdef HERLOA_EVAL_SQ_EN
    .sum_sq_ed(sq_a),
`endif
    .max_ed(max_a)
  );

  herloa_err_eval #(.N(N), .K(K), .CNT_W(CNT_W), .SEED(32'h8000_8000)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .num_samples(num_samples),
    .busy(busy_b), .done(done_b), .err_count(err_b), .sum_ed(sum_b),
`ifdef HERLOA_EVAL_SQ_EN
    .sum_sq_ed(sq_b),
`endif
    .max_ed(max_b)
  );

  logic        o_busy, o_done;
  logic [63:0] o_err, o_sum, o_max;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_err  = sel ? 64'(err_b) : 64'(err_a);
  assign o_sum  = sel ? 64'(sum_b) : 64'(sum_a);
  assign o_max  = sel ? 64'(max_b) : 64'(max_a);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_herloa(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        g;
    int          hi;
    g = a[K-1] & b[K-1];
    for (int i = 0; i < K - 1; i++) r[i] = a[i] | b[i] | g;
    r[K-1] = (a[K-1] ^ b[K-1]) | (a[K-2] & b[K-2]);
    hi = int'(a >> K) + int'(b >> K) + int'(g);
    for (int i = K; i < N; i++) r[i] = hi[i-K];
    return r;
  endfunction

  function automatic exp_t model_run(input logic [31:0] seed, input int m);
    exp_t        e;
    logic [31:0] l;
    logic [15:0] x, y, ex, ap, ed;
    e.err = 0; e.sum = 0; e.max = 0; e.m = m;
    e.cyc = (m == 0) ? 1 : m + 4;
    l = seed;
    for (int i = 0; i < m; i++) begin
      x  = l[15:0];
      y  = l[31:16];
      ex = x + y;
      ap = ref_herloa(x, y);
      ed = (ap > ex) ? ap - ex : ex - ap;
      if (ap != ex) e.err++;
      e.sum += 64'(ed);
      if (64'(ed) > e.max) e.max = 64'(ed);
      l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
    end
    return e;
  endfunction

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  task automatic run(input logic s, input int m, input bit spam, input string name);
    exp_t e;
    int   k, dk, done_cnt;
    bit   seen, busy_seen;
    sb.push_back(model_run(s ? 32'h8000_8000 : 32'hACE1_2345, m));
    @(negedge clk);
    sel = s;
    num_samples = CNT_W'(m);
    set_start(1'b1);
    @(posedge clk);
    #1;
    if (!spam) set_start(1'b0);
    k = 0; dk = 0; done_cnt = 0; seen = 0; busy_seen = 0;
    while (k < m + 20) begin
      @(negedge clk);
      k++;
      if (k == 1) check({name, "_busy_t1"}, 64'(o_busy), 64'(m > 0));
      if (o_busy) busy_seen = 1;
      if (o_done) begin
        done_cnt++;
        set_start(1'b0);
        if (!seen) begin
          seen = 1;
          dk = k;
          e = sb.pop_front();
          check({name, "_done_cycle"}, 64'(k), 64'(e.cyc));
          check({name, "_err_count"}, o_err, e.err);
          check({name, "_sum_ed"}, o_sum, e.sum);
          check({name, "_max_ed"}, o_max, e.max);
          check({name, "_err_le_n"}, 64'(o_err <= 64'(m)), 64'd1);
          check({name, "_sum_ge_max"}, 64'(o_sum >= o_max), 64'd1);
          check({name, "_busy_at_done"}, 64'(o_busy), 64'd0);
        end
      end
      if (seen && k == dk + 3) break;
    end
    set_start(1'b0);
    if (!seen) begin
      check({name, "_done_timeout"}, 64'd0, 64'd1);
      void'(sb.pop_front());
    end else begin
      check({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
      check({name, "_hold_err"}, o_err, e.err);
      check({name, "_hold_sum"}, o_sum, e.sum);
    end
    if (m == 0) check({name, "_busy_never"}, 64'(busy_seen), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    num_samples = '0;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_err", 64'(err_a), 64'd0);
    check("rst_sum", 64'(sum_a), 64'd0);
    check("rst_max", 64'(max_a), 64'd0);

    run(1'b1, 1, 1'b0, "seed8000");
    run(1'b0, 0, 1'b0, "zero");
    check("zero_err", o_err, 64'd0);
    check("zero_sum", o_sum, 64'd0);
    check("zero_max", o_max, 64'd0);
    run(1'b0, 10000, 1'b0, "long");
    run(1'b0, 100, 1'b1, "spam");

    // Abort a run midway with reset, then rerun cleanly.
    @(negedge clk);
    sel = 1'b0;
    num_samples = CNT_W'(100);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy_a), 64'd0);
    check("abort_err", 64'(err_a), 64'd0);
    check("abort_sum", 64'(sum_a), 64'd0);
    check("abort_max", 64'(max_a), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run(1'b0, 100, 1'b0, "rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
